// File: rtl/tft_pkg.sv
// tft_pkg: shared palette colours, pattern encoding and panel geometry defaults for the TFT test-pattern blocks
package tft_pkg;
  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  typedef enum logic [1:0] {PAT_BARS, PAT_SOLID, PAT_GRID, PAT_GRAD} pat_e;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] PURPLE = 16'hF81F;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] PALETTE [8] = '{BLACK, BLUE, RED, PURPLE, GREEN, CYAN, YELLOW, WHITE};
  function automatic logic [15:0] palette(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction
endpackage

// File: rtl/tft_pat_gen.sv
// tft_pat_gen: combinational RGB565 pixel for (pat_id, color_idx, hcount, vcount) -> pix, zero outside the active area
module tft_pat_gen import tft_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  pat_e        pat_id,
  input  logic [2:0]  color_idx,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] pix
);
  localparam logic [9:0] H_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_END = 10'(V_ACTIVE);
  logic [2:0] bar;
  logic       grid_on;
  always_comb begin
    bar = 3'(hcount / 10'd60);
    grid_on = hcount[3:0] == 4'd0 || vcount[3:0] == 4'd0 ||
              hcount == H_END - 10'd1 || vcount == V_END - 10'd1;
    pix = (hcount >= H_END || vcount >= V_END) ? BLACK :
          pat_id == PAT_BARS  ? palette(bar) :
          pat_id == PAT_SOLID ? palette(color_idx) :
          pat_id == PAT_GRID  ? (grid_on ? WHITE : BLACK) :
          {hcount[8:4], vcount[8:3], 5'd0};
  end
endmodule

// File: rtl/tft_pattern_sched.sv
// tft_pattern_sched: frame-synchronous test-pattern scheduler; in clk/rst/hcount/vcount/pause/next_req, out registered disp_data, pat_id, frame_tick
module tft_pattern_sched import tft_pkg::*; #(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int FRAMES_PER_PAT = 120,
  parameter int SOLID_STEP     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        pause,
  input  logic        next_req,
  output logic [15:0] disp_data,
  output logic [1:0]  pat_id,
  output logic        frame_tick
);
  localparam int DW = $clog2(FRAMES_PER_PAT);
  localparam int SW = SOLID_STEP > 1 ? $clog2(SOLID_STEP) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_PAT - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(SOLID_STEP - 1);
  localparam logic [9:0] V_FB = 10'(V_ACTIVE);
  logic          at_fb_q, at_fb_d;
  logic          frame_tick_q, frame_tick_d;
  logic          next_pend_q, next_pend_d;
  pat_e          pat_q, pat_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] step_q, step_d;
  logic [2:0]    color_q, color_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pix;
  logic          pend, adv, run, solid_run, step_wrap;
  tft_pat_gen #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_gen (
    .pat_id(pat_q),
    .color_idx(color_q),
    .hcount(hcount),
    .vcount(vcount),
    .pix(pix)
  );
  always_comb begin
    at_fb_d = vcount == V_FB && hcount == 10'd0;
    frame_tick_d = at_fb_d && !at_fb_q;
    pend = next_pend_q || next_req;
    adv = frame_tick_q && (pend || (!pause && dwell_q == DWELL_LAST));
    run = frame_tick_q && !adv && !pause;
    solid_run = run && pat_q == PAT_SOLID;
    step_wrap = step_q == STEP_LAST;
    next_pend_d = pend && !adv;
    pat_d = adv ? pat_e'(pat_q + 2'd1) : pat_q;
    dwell_d = adv ? '0 : run ? dwell_q + DW'(1) : dwell_q;
    step_d = adv ? '0 : solid_run ? (step_wrap ? '0 : step_q + SW'(1)) : step_q;
    color_d = adv ? 3'd0 : (solid_run && step_wrap) ? color_q + 3'd1 : color_q;
    disp_d = pix;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_fb_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      next_pend_q  <= 1'b0;
      pat_q        <= PAT_BARS;
      dwell_q      <= '0;
      step_q       <= '0;
      color_q      <= 3'd0;
      disp_q       <= 16'h0000;
    end else begin
      at_fb_q      <= at_fb_d;
      frame_tick_q <= frame_tick_d;
      next_pend_q  <= next_pend_d;
      pat_q        <= pat_d;
      dwell_q      <= dwell_d;
      step_q       <= step_d;
      color_q      <= color_d;
      disp_q       <= disp_d;
    end
  end
  assign disp_data  = disp_q;
  assign pat_id     = pat_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: doc/tft_pattern_sched.md
# tft_pattern_sched

Frame-synchronous test-pattern scheduler for the 480x272 TFT panel. Takes the `hcount`/`vcount` pixel coordinates from `tft_ctrl` and returns a registered RGB565 pixel on `disp_data`, which feeds `tft_ctrl.data_in`. It cycles through four test patterns, with an automatic dwell time per pattern and a manual advance request. Pattern changes take effect only at the start of vertical blanking, so a frame never tears.

## Interface
- `H_ACTIVE`, default 480: active pixels per line.
- `V_ACTIVE`, default 272: active lines per frame.
- `FRAMES_PER_PAT`, default 120: frames each pattern is shown before it auto-advances. Must be ≥ 2.
- `SOLID_STEP`, default 16: frames per colour step in the SOLID pattern.
- `clk` in, 1 bit: pixel clock (`clk_9m` domain). One clock only.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `hcount` in, 10 bits: current column from `tft_ctrl`.
- `vcount` in, 10 bits: current line from `tft_ctrl`.
- `pause` in, 1 bit: level input; freezes the dwell counter and the SOLID colour counter.
- `next_req` in, 1 bit: single-cycle pulse; requests a pattern advance at the next frame boundary.
- `disp_data` out, 16 bits: RGB565 pixel, registered.
- `pat_id` out, 2 bits: current pattern.
- `frame_tick` out, 1 bit: one-cycle pulse marking a frame boundary.

## Operation
- **Palette**, index 0 to 7: BLACK 0000, BLUE 001F, RED F800, PURPLE F81F, GREEN 07E0, CYAN 07FF, YELLOW FFE0, WHITE FFFF.
- **Patterns** (`pat_id`):
  - 0 BARS: eight vertical bars, each 60 px wide. Palette index = `hcount`/60.
  - 1 SOLID: whole screen shows `palette[color_idx]`.
  - 2 GRID: WHITE when `hcount[3:0]`==0, `vcount[3:0]`==0, `hcount`==`H_ACTIVE`-1 or `vcount`==`V_ACTIVE`-1. BLACK otherwise.
  - 3 GRAD: R=`hcount[8:4]`, G=`vcount[8:3]`, B=0.
- **Blanking:** when `hcount`≥`H_ACTIVE` or `vcount`≥`V_ACTIVE`, pixel = 0000 regardless of pattern.
- **Frame boundary detection:**
  - `at_fb` = (`vcount`==`V_ACTIVE` && `hcount`==0), registered into `at_fb_q`.
  - `frame_tick` = `at_fb` && !`at_fb_q`, registered. It fires exactly once per frame even if the coordinates stall.
- **Request latch:** `next_req` sets `next_pend`. `next_pend` is cleared only when the advance is consumed.
- **Scheduler state:** `pat_id` (2b), `dwell_cnt` (0..`FRAMES_PER_PAT`-1), `color_idx` (3b), `step_cnt` (0..`SOLID_STEP`-1), `next_pend`.
- **On `frame_tick`, evaluated in priority order:**
  1. Advance if `next_pend`, or if (!`pause` && `dwell_cnt`==`FRAMES_PER_PAT`-1):
     - `pat_id` ← `pat_id`+1; wraps 3→0.
     - `dwell_cnt`, `color_idx`, `step_cnt` ← 0.
     - `next_pend` ← 0.
  2. Else if !`pause`: `dwell_cnt`++. If `pat_id`==SOLID, `step_cnt`++; when `step_cnt` wraps, `color_idx`++ (7→0 wrap).
  3. Else (`pause`): hold everything.
- **Simultaneous events:**
  - `next_req` in the same cycle as a dwell-expiry boundary: exactly one advance, and `next_pend` ends at 0.
  - `next_req` in the same cycle as `frame_tick`: counts as pending, so the advance happens at that same boundary.
  - `next_req` during `pause`: still advances at the next boundary.

## Timing
- `disp_data` is registered with 1-cycle latency from `hcount`/`vcount`. The integrator aligns `tft_ctrl` sampling to this latency.
- `frame_tick` rises 1 cycle after the first cycle of `at_fb`.
- `pat_id`, `color_idx` and the counters update on the same edge that `frame_tick` is high. The new pattern is visible from the first `disp_data` of the next frame, since all pixels during vertical blanking are 0.
- Reset values: `disp_data`=0000, `pat_id`=0, `frame_tick`=0. Internal state: `dwell_cnt`=0, `color_idx`=0, `step_cnt`=0, `next_pend`=0, `at_fb_q`=0.
- Reset asserted mid-frame: all state returns to the reset values immediately. Scheduling restarts with BARS at the next boundary count.

## Structure
- Shared package `tft_pkg` holds:
  - The eight palette colour constants.
  - The pattern encoding (BARS/SOLID/GRID/GRAD).
  - `H_ACTIVE`/`V_ACTIVE` defaults.
- Sub-module `tft_pat_gen`: a purely combinational function of (`pat_id`, `color_idx`, `hcount`, `vcount`) returning the pixel.
- The top level holds the boundary detector, request latch, counters, scheduler FSM and the output register.

## Test plan
Benches use `FRAMES_PER_PAT`=4, `SOLID_STEP`=2 and a behavioural 525x288 counter model.
- **Reset:** assert `rst` mid-line → `disp_data`=0000 and `pat_id`=0 immediately. After release, (`hcount`=59,`vcount`=10) gives 0000 and (60,10) gives 001F, each one cycle later.
- **Auto dwell:** free-run with no requests → `pat_id` steps 0→1→2→3→0. Each step comes on every 4th `frame_tick`; `frame_tick` is exactly one pulse per frame.
- **SOLID colours:** in `pat_id`=1, the pixel at (100,100) shows 0000 for 2 frames, then 001F for 2 frames, then the pattern advances.
- **Manual advance:** pulse `next_req` mid-frame at `dwell_cnt`=0 → `pat_id` increments at the next boundary only. It increments once even when the pulse coincides with dwell expiry.
- **Pause:** hold `pause` for 10 frames → `pat_id` is unchanged. A `next_req` pulsed during pause advances exactly one pattern at the next boundary.
- **GRID and blanking:** GRID gives FFFF at (16,5), 0000 at (17,5) and FFFF at (479,5). Any pattern at (480,0) or (0,272) gives 0000.
